// File: rtl/cnt_arb_pkg.sv
// Shared definitions for the round-robin counter arbiter: FSM encoding and default sizing.
package cnt_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StGap   = 2'd2
    } arb_state_e;

    localparam int unsigned DefN       = 4;
    localparam int unsigned DefIdw     = 2;
    localparam int unsigned DefMaxHold = 8;
    localparam int unsigned DefHw      = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first asserted request at base, base+1, ...
// with the index wrapping by IDW-bit truncation.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] base_i,
    output logic           valid_o,
    output logic [IDW-1:0] sel_o
);

    logic [IDW-1:0] idx;

    // Scan from base upward; the first hit wins and later hits are ignored.
    always_comb begin
        valid_o = 1'b0;
        sel_o   = '0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = base_i + IDW'(i);
            if (!valid_o && req_i[idx]) begin
                valid_o = 1'b1;
                sel_o   = idx;
            end
        end
    end

endmodule

// File: rtl/cnt_rr_arbiter.sv
// Round-robin arbiter for a shared counter datapath: one grantee at a time, bounded hold,
// one dead cycle between grants, priority rotating past the last grantee.
module cnt_rr_arbiter
    import cnt_arb_pkg::*;
#(
    parameter int unsigned N        = DefN,
    parameter int unsigned IDW      = DefIdw,
    parameter int unsigned MAX_HOLD = DefMaxHold,
    parameter int unsigned HW       = DefHw
) (
    input  logic           w_clk,
    input  logic           w_rst,
    input  logic [N-1:0]   w_req,
    input  logic [N-1:0]   w_done,
    output logic [N-1:0]   w_gnt,
    output logic [IDW-1:0] w_gnt_id,
    output logic           w_busy,
    output logic           w_timeout
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           busy_q, busy_d;
    logic           timeout_q, timeout_d;

    logic           pick_valid;
    logic [IDW-1:0] pick_sel;
    logic           own_done;
    logic           own_req;
    logic           hold_max;
    logic           release_now;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req_i   (w_req),
        .base_i  (ptr_q),
        .valid_o (pick_valid),
        .sel_o   (pick_sel)
    );

    // Only the current grantee's done/req bits matter; all others are ignored.
    assign own_done    = w_done[gnt_id_q];
    assign own_req     = w_req[gnt_id_q];
    assign hold_max    = (hold_q == HW'(MAX_HOLD - 1));
    assign release_now = own_done || !own_req || hold_max;

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state: IDLE -> GRANT on any request, GRANT -> GAP on release, GAP lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (pick_valid) state_d = StGrant;
            StGrant: if (release_now) state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and output next values for the grant, pointer and hold counter.
    always_comb begin
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (pick_valid) begin
                    gnt_d[pick_sel] = 1'b1;
                    gnt_id_d        = pick_sel;
                    hold_d          = '0;
                    busy_d          = 1'b1;
                end
            end
            StGrant: begin
                if (release_now) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_d     = gnt_id_q + IDW'(1);
                    hold_d    = '0;
                    // Forced release only when neither done nor withdrawal ended the grant.
                    timeout_d = !own_done && own_req;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            StGap: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign w_gnt     = gnt_q;
    assign w_gnt_id  = gnt_id_q;
    assign w_busy    = busy_q;
    assign w_timeout = timeout_q;

endmodule

// File: tb/tb_cnt_rr_arbiter.sv
// Self-checking bench for cnt_rr_arbiter: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural model of the arbitration rules.
module tb_cnt_rr_arbiter;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 8;
    localparam int HW       = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    cnt_rr_arbiter #(
        .N        (N),
        .IDW      (IDW),
        .MAX_HOLD (MAX_HOLD),
        .HW       (HW)
    ) dut (
        .w_clk     (clk),
        .w_rst     (rst),
        .w_req     (req),
        .w_done    (done),
        .w_gnt     (gnt),
        .w_gnt_id  (gnt_id),
        .w_busy    (busy),
        .w_timeout (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: who owns the resource, how many cycles it has held it, where priority starts.
    int   m_mode;   // 0 waiting for requests, 1 owned, 2 turnaround
    int   m_ptr;
    int   m_owner;
    int   m_held;
    int   e_gnt;
    int   e_id;
    int   e_busy;
    int   e_to;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        int cand;
        if (rst) begin
            m_mode = 0; m_ptr = 0; m_held = 0;
            e_gnt = 0; e_id = 0; e_busy = 0; e_to = 0;
            return;
        end
        e_to = 0;
        case (m_mode)
            0: begin
                e_gnt = 0; e_busy = 0;
                for (int k = 0; k < N; k++) begin
                    cand = (m_ptr + k) % N;
                    if (m_mode == 0 && req[cand]) begin
                        m_owner = cand; m_held = 1; m_mode = 1;
                        e_gnt = 1 << cand; e_id = cand; e_busy = 1;
                    end
                end
            end
            1: begin
                if (done[m_owner] || !req[m_owner] || m_held == MAX_HOLD) begin
                    e_to   = (!done[m_owner] && req[m_owner]) ? 1 : 0;
                    m_ptr  = (m_owner + 1) % N;
                    m_mode = 2;
                    e_gnt = 0; e_busy = 0;
                end else begin
                    m_held++;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    // One clock: model follows the edge, outputs compared half a cycle later.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_eq("gnt", gnt, e_gnt);
        check_eq("gnt_id", gnt_id, e_id);
        check_eq("busy", busy, e_busy);
        check_eq("timeout", timeout, e_to);
    endtask

    int hi_cnt;
    int to_cnt;

    initial begin
        m_mode = 0; m_ptr = 0; m_owner = 0; m_held = 0;
        e_gnt = 0; e_id = 0; e_busy = 0; e_to = 0;
        rst = 1'b1; req = 4'b1111; done = '0;
        @(negedge clk);

        // Reset dominates pending requests.
        step(); step();
        check_eq("reset_gnt", gnt, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_id", gnt_id, 0);
        rst = 1'b0; req = '0;
        step();

        // Single request, one-cycle latency, released by done.
        req = 4'b0100;
        step();
        check_eq("single_gnt", gnt, 4'b0100);
        check_eq("single_id", gnt_id, 2);
        step();
        done = 4'b0100;
        step();
        check_eq("single_release", gnt, 0);
        done = '0; req = '0;
        step(); step();
        // Pointer now 3: full request set must go to 3 first.
        req = 4'b1111;
        step();
        check_eq("ptr_after_single", gnt_id, 3);
        done = 4'b1000;
        step();
        done = '0; req = '0;
        step(); step();

        // Rotation with wrap 3 -> 0.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("rotate_id", gnt_id, i % N);
            step();
            done = '0;
            done[i % N] = 1'b1;
            step();
            done = '0;
            step();
        end
        req = '0;
        step(); step();

        // Forced release after MAX_HOLD cycles, then regrant to the only requester.
        req = 4'b0001;
        hi_cnt = 0; to_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gnt == 4'b0001) hi_cnt++;
            if (timeout) to_cnt++;
        end
        check_eq("timeout_hold_cycles", hi_cnt, MAX_HOLD);
        check_eq("timeout_pulses", to_cnt, 1);
        step();
        check_eq("timeout_regrant", gnt, 4'b0001);
        req = '0;
        step(); step(); step();

        // Done coinciding with the last allowed hold cycle suppresses the timeout.
        req = 4'b0001;
        for (int i = 0; i < MAX_HOLD; i++) step();
        done = 4'b0001;
        step();
        check_eq("done_vs_timeout_to", timeout, 0);
        check_eq("done_vs_timeout_gnt", gnt, 0);
        done = '0; req = '0;
        step(); step();

        // Stray done ignored, then reset mid-grant.
        req = 4'b0010;
        step();
        check_eq("mid_gnt", gnt, 4'b0010);
        done = 4'b1000;
        step();
        check_eq("stray_done_ignored", gnt, 4'b0010);
        done = '0;
        rst = 1'b1;
        step();
        check_eq("mid_reset_gnt", gnt, 0);
        rst = 1'b0; req = 4'b1111;
        step();
        check_eq("mid_reset_ptr", gnt_id, 0);
        req = '0;
        step(); step(); step();

        // Randomized traffic: slowly changing requests, random done strobes, rare resets.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            end
            done = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
            rst  = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
